// File: rtl/program_loader.sv
// program_loader
//   Writer side of the instruction RAM. Receives a framed program image as a
//   byte stream (LEN_HI, LEN_LO, 4*N data bytes MSB first, CSUM), packs the bytes
//   into big-endian words and writes them through RAM port A starting at
//   BOOT_ADDR. CSUM is the XOR of every preceding byte, length bytes included.
//   The CPU is held in reset until a complete frame with a good checksum lands.
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   rx_data/valid   incoming byte stream; accepted when rx_valid & rx_ready
//   rx_ready        high while a frame can be received (LEN_HI..CHECK)
//   reload          one-cycle pulse in DONE/ERROR starts a new load
//   ram_we_a        port A write pulse, one cycle after a word's last byte
//   ram_addr_a      port A word address
//   ram_wdata_a     port A write data
//   cpu_rst         CPU reset, low only in DONE
//   done / error    image good / checksum, oversize length or timeout
module program_loader #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned WORD_WIDTH = 32,
   parameter logic [31:0] BOOT_ADDR  = 32'h00000000,
   parameter int unsigned TIMEOUT    = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic                  reload,
   output logic                  ram_we_a,
   output logic [ADDR_WIDTH-1:0] ram_addr_a,
   output logic [WORD_WIDTH-1:0] ram_wdata_a,
   output logic                  cpu_rst,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned          TO_W      = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [16:0]          MAX_WORDS = 17'(2 ** ADDR_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] BOOT     = BOOT_ADDR[ADDR_WIDTH-1:0];

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                  state_q, state_d;
   logic [15:0]             count_q, count_d;
   logic [15:0]             words_q, words_d;
   logic [1:0]              bytes_q, bytes_d;
   logic [7:0]              csum_q, csum_d;
   logic [WORD_WIDTH-1:0]   word_q, word_d;
   logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    we_q, we_d;
   logic [TO_W-1:0]         to_q, to_d;

   logic                    accept;
   logic                    timing;
   logic [15:0]             len_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_LEN_HI;
         count_q <= '0;
         words_q <= '0;
         bytes_q <= '0;
         csum_q  <= '0;
         word_q  <= '0;
         wdata_q <= '0;
         addr_q  <= BOOT;
         we_q    <= 1'b0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         words_q <= words_d;
         bytes_q <= bytes_d;
         csum_q  <= csum_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         to_q    <= to_d;
      end
   end

   assign rx_ready = (state_q != S_DONE) && (state_q != S_ERROR);
   assign accept   = rx_valid && rx_ready;
   assign timing   = (state_q == S_LEN_LO) || (state_q == S_DATA) || (state_q == S_CHECK);
   assign len_full = {count_q[15:8], rx_data};

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      words_d = words_q;
      bytes_d = bytes_q;
      csum_d  = csum_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      addr_d  = addr_q;
      we_d    = 1'b0;
      to_d    = to_q;

      // Address advances the cycle after the write pulse it belonged to.
      if (we_q) begin
         addr_d = addr_q + 1'b1;
      end

      if (accept) begin
         to_d   = '0;
         csum_d = csum_q ^ rx_data;
      end else if (timing) begin
         if (to_q == TO_LAST) begin
            state_d = S_ERROR;
         end else begin
            to_d = to_q + 1'b1;
         end
      end

      case (state_q)
         S_LEN_HI: begin
            if (accept) begin
               count_d[15:8] = rx_data;
               state_d       = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               count_d[7:0] = rx_data;
               if ({1'b0, len_full} > MAX_WORDS) begin
                  state_d = S_ERROR;
               end else if (len_full == 16'd0) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               word_d  = {word_q[WORD_WIDTH-9:0], rx_data};
               bytes_d = bytes_q + 1'b1;
               if (bytes_q == 2'd3) begin
                  we_d    = 1'b1;
                  wdata_d = word_d;
                  words_d = words_q + 16'd1;
                  if (words_q + 16'd1 == count_q) begin
                     state_d = S_CHECK;
                  end
               end
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
            end
         end
         S_DONE, S_ERROR: begin
            if (reload) begin
               state_d = S_LEN_HI;
               count_d = '0;
               words_d = '0;
               bytes_d = '0;
               csum_d  = '0;
               addr_d  = BOOT;
               to_d    = '0;
            end
         end
         default: state_d = S_LEN_HI;
      endcase
   end

   assign ram_we_a    = we_q;
   assign ram_addr_a  = addr_q;
   assign ram_wdata_a = wdata_q;
   // reload raises cpu_rst in the very cycle it is seen, not one cycle later.
   assign cpu_rst     = (state_q != S_DONE) || reload;
   assign done        = (state_q == S_DONE);
   assign error       = (state_q == S_ERROR);

endmodule
